// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver that turns an async codec ADC stream into left/right sample frames in the clk_100 domain.
// Define I2S_RX_MONO_MIX_EN to add the registered sample_mono output.
module i2s_rx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk_100,
  input  logic                    reset,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lr,
  input  logic                    i2s_sdata,
  output logic [SAMPLE_WIDTH-1:0] sample_l,
  output logic [SAMPLE_WIDTH-1:0] sample_r,
  output logic                    sample_valid,
  output logic                    short_word,
`ifdef I2S_RX_MONO_MIX_EN
  output logic [SAMPLE_WIDTH-1:0] sample_mono,
`endif
  output logic                    locked
);
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(SAMPLE_WIDTH);
  localparam logic [CW-1:0] TOP = CW'(SAMPLE_WIDTH - 1);

  typedef enum logic [1:0] {UNLOCKED, ARMED, LOCKED} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic bclk_prev_q, bclk_prev_d, rise_q, rise_d, lr_q, lr_d, sd_q, sd_d;
  logic lr_prev_q, lr_prev_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d, hold_q, hold_d, word;
  logic [SAMPLE_WIDTH-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic valid_q, valid_d, short_q, short_d;
  logic bclk_s, lr_s, sd_s, is_short;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {i2s_bclk, i2s_lr, i2s_sdata}};
    {bclk_s, lr_s, sd_s} = sync_q[SYNC_STAGES-1];
    bclk_prev_d = bclk_s;
    rise_d = bclk_s & ~bclk_prev_q;
    lr_d = lr_s;
    sd_d = sd_s;
    state_d = state_q;
    lr_prev_d = lr_prev_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d = shreg_q;
    hold_d = hold_q;
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    valid_d = 1'b0;
    short_d = 1'b0;
    word = shreg_q;
    is_short = 1'b0;
    if (rise_q) begin
      if (bit_cnt_q < FULL) begin
        word[TOP - bit_cnt_q] = sd_q;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      shreg_d = word;
      // An lr change marks this bit as the LSB slot of the word that just ended.
      if (lr_q != lr_prev_q) begin
        is_short = bit_cnt_d < FULL;
        short_d = (state_q == LOCKED) && is_short;
        if (!lr_prev_q) begin
          hold_d = word;
          state_d = (state_q == ARMED) ? LOCKED : state_q;
        end else begin
          valid_d = state_q == LOCKED;
          sample_l_d = valid_d ? hold_q : sample_l_q;
          sample_r_d = valid_d ? word : sample_r_q;
          state_d = (state_q == UNLOCKED) ? ARMED : state_q;
        end
        shreg_d = '0;
        bit_cnt_d = '0;
        lr_prev_d = lr_q;
      end
    end
  end

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state_q <= UNLOCKED;
      sync_q <= '0;
      bclk_prev_q <= 1'b0;
      rise_q <= 1'b0;
      lr_q <= 1'b0;
      sd_q <= 1'b0;
      lr_prev_q <= 1'b1;
      bit_cnt_q <= '0;
      shreg_q <= '0;
      hold_q <= '0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      valid_q <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      bclk_prev_q <= bclk_prev_d;
      rise_q <= rise_d;
      lr_q <= lr_d;
      sd_q <= sd_d;
      lr_prev_q <= lr_prev_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q <= shreg_d;
      hold_q <= hold_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      valid_q <= valid_d;
      short_q <= short_d;
    end
  end

`ifdef I2S_RX_MONO_MIX_EN
  logic signed [SAMPLE_WIDTH:0] mono_sum;
  logic [SAMPLE_WIDTH-1:0] mono_q, mono_d;

  always_comb begin
    mono_sum = $signed({sample_l_d[SAMPLE_WIDTH-1], sample_l_d}) + $signed({sample_r_d[SAMPLE_WIDTH-1], sample_r_d});
    mono_d = mono_sum[SAMPLE_WIDTH:1];
  end

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) mono_q <= '0;
    else mono_q <= mono_d;
  end

  assign sample_mono = mono_q;
`endif

  assign sample_l = sample_l_q;
  assign sample_r = sample_r_q;
  assign sample_valid = valid_q;
  assign short_word = short_q;
  assign locked = state_q == LOCKED;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: random and directed I2S streams checked against a word-level reference model.
module tb_i2s_rx;
  logic clk = 0, reset = 1, bclk = 0, lr_i = 0, sd_i = 0;
  logic [23:0] sample_l, sample_r;
  logic sample_valid, short_word, locked;
`ifdef I2S_RX_MONO_MIX_EN
  logic [23:0] sample_mono;
`endif

  i2s_rx dut (
    .clk_100(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lr(lr_i), .i2s_sdata(sd_i),
    .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
    .short_word(short_word),
`ifdef I2S_RX_MONO_MIX_EN
    .sample_mono(sample_mono),
`endif
    .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {logic [23:0] l; logic [23:0] r; bit sh;} frame_t;
  frame_t exp_q[$];
  int n_vec = 0, n_err = 0, cyc = 0, rise_cyc = 0, exp_short = 0, obs_short = 0;
  bit carry = 0;
  // reference model: bits of the open word, last lr, lock progress (0 none, 1 armed, 2 locked)
  bit bits_q[$];
  bit m_prev = 1;
  int lk = 0;
  logic [23:0] m_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_rise(input bit lr, input bit sd);
    logic [23:0] w;
    bit sh;
    bits_q.push_back(sd);
    if (lr != m_prev) begin
      w = 0;
      for (int i = 0; i < 24 && i < bits_q.size(); i++) w[23-i] = bits_q[i];
      sh = bits_q.size() < 24;
      if (lk == 2 && sh) exp_short++;
      if (!m_prev) begin
        m_hold = w;
        if (lk == 1) lk = 2;
      end else begin
        if (lk == 2) exp_q.push_back('{l: m_hold, r: w, sh: sh});
        if (lk == 0) lk = 1;
      end
      bits_q.delete();
      m_prev = lr;
    end
  endtask

  task automatic send_bit(input bit lr, input bit sd, input int half);
    repeat (half) @(posedge clk);
    #2 bclk = 0; lr_i = lr; sd_i = sd;
    repeat (half) @(posedge clk);
    #2 bclk = 1; rise_cyc = cyc; m_rise(lr, sd);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_l"}, 32'(sample_l), 0);
    check({tag, "_r"}, 32'(sample_r), 0);
    check({tag, "_valid"}, 32'(sample_valid), 0);
    check({tag, "_short"}, 32'(short_word), 0);
    check({tag, "_locked"}, 32'(locked), 0);
  endtask

  task automatic mid_reset(input int half);
    repeat (half) @(posedge clk);
    #2 bclk = 0; reset = 1;
    #1 check_cleared("midrst");
    bits_q.delete(); m_prev = 1; lk = 0;
    repeat (3) @(posedge clk);
    #2 reset = 0;
  endtask

  // One channel slot: one-bclk I2S delay, so the slot opens with the previous word's LSB.
  task automatic send_slot(input bit lr, input logic [31:0] w, input int n, input int half, input int rst_at);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) mid_reset(half);
      send_bit(lr, i == 0 ? carry : w[32-i], half);
    end
    carry = w[32-n];
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nl, input int nr, input int half);
    send_slot(0, l, nl, half, -1);
    send_slot(1, r, nr, half, -1);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (short_word) obs_short++;
      if (sample_valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          frame_t e;
          logic signed [24:0] s;
          e = exp_q.pop_front();
          s = $signed({e.l[23], e.l}) + $signed({e.r[23], e.r});
          check("sample_l", 32'(sample_l), 32'(e.l));
          check("sample_r", 32'(sample_r), 32'(e.r));
          check("short_at_valid", 32'(short_word), 32'(e.sh));
          check("locked_at_valid", 32'(locked), 1);
          check("latency", 32'(cyc - rise_cyc), 4);
`ifdef I2S_RX_MONO_MIX_EN
          check("sample_mono", 32'(sample_mono), 32'(s[24:1]));
`endif
          if (s == 0) n_vec += 0;
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_cleared("reset");
    @(posedge clk); #2 reset = 0;
    for (int f = 0; f < 5; f++) send_frame(32'h12345600, 32'hFEDCBA00, 32, 32, 16);
    repeat (6) @(posedge clk);
    #1 check("nominal_l", 32'(sample_l), 32'h123456);
    check("nominal_r", 32'(sample_r), 32'hFEDCBA);
    check("nominal_locked", 32'(locked), 1);
    for (int f = 0; f < 4; f++) send_frame(32'hABCD0000, 32'h80010000, 16, 16, 16);
    repeat (6) @(posedge clk);
    #1 check("short_l", 32'(sample_l), 32'hABCD00);
    check("short_r", 32'(sample_r), 32'h800100);
    for (int f = 0; f < 4; f++) send_frame($urandom, $urandom, 32, 32, 4);
    send_frame(32'h7FFFFF00, 32'h7FFFFF00, 24, 24, 4);
    send_frame(32'h80000000, 32'h00000000, 24, 24, 4);
    send_frame(32'h7FFFFF00, 32'h7FFFFF00, 24, 24, 4);
    send_slot(0, $urandom, 32, 4, -1);
    send_slot(1, $urandom, 32, 4, 10);
    for (int f = 0; f < 20; f++)
      send_frame($urandom, $urandom, $urandom_range(8, 32), $urandom_range(8, 32), 4);
    send_slot(0, $urandom, 24, 4, -1);
    repeat (20) @(posedge clk);
    #1 check("drain", 32'(exp_q.size()), 0);
    check("short_count", 32'(obs_short), 32'(exp_short));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
